mmio_led_reg: RTL and testbench

Memory-mapped LED register stage sitting between the CPU data-memory/IO bus and the LED output driver. Decodes CPU stores and loads to three LED-control addresses, holds the LED pattern, and produces the select strobe and data word the LED driver consumes every cycle. Adds hardware blink and rotate modes driven by a programmable tick counter, so software writes once and the display animates without further stores.

---
 rtl/mmio_led_reg.sv | 228 ++++++++++++++++++++++
 tb/tb_mmio_led_reg.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_led_reg.sv
//-----------------------------------------------------------------------------
// mmio_led_reg
//
// Memory-mapped LED register stage between the CPU data-memory/IO bus and
// the LED output driver. Three word registers are decoded on the bus:
//   LED_ADDR + 0 : LED pattern   (16 bits, read back as {16'b0, pattern})
//   LED_ADDR + 4 : MODE          (2 bits: 0 static, 1 blink, 2 rotate, 3 = 0)
//   LED_ADDR + 8 : PERIOD        (24 bits, clock cycles per tick minus one)
// A free-running tick counter animates the display in blink and rotate
// modes so software only has to store once.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   addr         CPU byte address (addr[1:0] ignored)
//   mem_write    store strobe, one cycle per store
//   mem_read     load strobe, one cycle per load
//   wdata        store data
//   rdata        registered load data (zero when no hit load)
//   rdata_valid  one-cycle pulse with rdata on a hit load
//   led_ctrl     select strobe to LED driver (low = LEDs dark)
//   led_word     data word to LED driver, bits [31:16] always zero
//-----------------------------------------------------------------------------
module mmio_led_reg #(
    parameter logic [31:0] LED_ADDR   = 32'hFFFF_FC60,
    parameter logic [23:0] PERIOD_RST = 24'd12_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        led_ctrl,
    output logic [31:0] led_word
);

    // Word addresses of the three registers.
    localparam logic [29:0] LED_WADDR    = LED_ADDR[31:2];
    localparam logic [29:0] MODE_WADDR   = LED_WADDR + 30'd1;
    localparam logic [29:0] PERIOD_WADDR = LED_WADDR + 30'd2;

    // Display modes (mode 3 is reserved and treated as static).
    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_ROTATE = 2'd2;

    // Rotate a 16-bit pattern left by one, bit 15 wrapping into bit 0.
    function automatic logic [15:0] rotl1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    // Architectural state.
    logic [15:0] r_led;
    logic [1:0]  r_mode;
    logic [23:0] r_period;
    logic [23:0] r_cnt;
    logic        r_phase;
    logic [15:0] r_disp;
    logic [31:0] r_rdata;
    logic        r_rdata_valid;

    // Decode and control wires.
    logic        w_hit_led;
    logic        w_hit_mode;
    logic        w_hit_period;
    logic        w_store_led;
    logic        w_store_mode;
    logic        w_store_period;
    logic        w_store_any;
    logic        w_run;
    logic        w_tick;
    logic [31:0] w_rd_mux;
    logic        w_rd_hit;

    // Byte-lane bits and the unused upper store bits carry no information.
    logic w_unused_bits;
    assign w_unused_bits = ^{addr[1:0], wdata[31:24]};

    // Address decode and store qualification.
    always_comb begin
        w_hit_led      = (addr[31:2] == LED_WADDR);
        w_hit_mode     = (addr[31:2] == MODE_WADDR);
        w_hit_period   = (addr[31:2] == PERIOD_WADDR);
        w_store_led    = mem_write & w_hit_led;
        w_store_mode   = mem_write & w_hit_mode;
        w_store_period = mem_write & w_hit_period;
        w_store_any    = w_store_led | w_store_mode | w_store_period;
    end

    // Tick counter enable: only animated modes count, and any hit store
    // restarts the count instead of advancing it.
    always_comb begin
        w_run = 1'b0;
        if (w_store_any) begin
            w_run = 1'b0;
        end else begin
            case (r_mode)
                MODE_BLINK:  w_run = 1'b1;
                MODE_ROTATE: w_run = 1'b1;
                default:     w_run = 1'b0;
            endcase
        end
        w_tick = w_run & (r_cnt >= r_period);
    end

    // Load data mux, sampled from pre-store register values.
    always_comb begin
        w_rd_mux = 32'h0000_0000;
        w_rd_hit = 1'b0;
        if (mem_read) begin
            case ({w_hit_led, w_hit_mode, w_hit_period})
                3'b100: begin
                    w_rd_mux = {16'h0000, r_led};
                    w_rd_hit = 1'b1;
                end
                3'b010: begin
                    w_rd_mux = {30'h0000_0000, r_mode};
                    w_rd_hit = 1'b1;
                end
                3'b001: begin
                    w_rd_mux = {8'h00, r_period};
                    w_rd_hit = 1'b1;
                end
                default: begin
                    w_rd_mux = 32'h0000_0000;
                    w_rd_hit = 1'b0;
                end
            endcase
        end else begin
            w_rd_mux = 32'h0000_0000;
            w_rd_hit = 1'b0;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led    <= 16'h0000;
            r_mode   <= MODE_STATIC;
            r_period <= PERIOD_RST;
        end else begin
            if (w_store_led) begin
                r_led <= wdata[15:0];
            end
            if (w_store_mode) begin
                r_mode <= wdata[1:0];
            end
            if (w_store_period) begin
                r_period <= wdata[23:0];
            end
        end
    end

    // Animation state: tick counter, blink phase and rotating display image.
    // LED and MODE stores restart the animation from its visible start point
    // (phase on, display = pattern); a PERIOD store only restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 24'h00_0000;
            r_phase <= 1'b1;
            r_disp  <= 16'h0000;
        end else if (w_store_led) begin
            r_cnt   <= 24'h00_0000;
            r_phase <= 1'b1;
            r_disp  <= wdata[15:0];
        end else if (w_store_mode) begin
            r_cnt   <= 24'h00_0000;
            r_phase <= 1'b1;
            r_disp  <= r_led;
        end else if (w_store_period) begin
            r_cnt   <= 24'h00_0000;
        end else if (w_tick) begin
            r_cnt <= 24'h00_0000;
            if (r_mode == MODE_BLINK) begin
                r_phase <= ~r_phase;
            end
            if (r_mode == MODE_ROTATE) begin
                r_disp <= rotl1(r_disp);
            end
        end else if (w_run) begin
            r_cnt <= r_cnt + 24'h00_0001;
        end
    end

    // Registered load response; a miss or idle cycle returns zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata       <= 32'h0000_0000;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata       <= w_rd_mux;
            r_rdata_valid <= w_rd_hit;
        end
    end

    assign rdata       = r_rdata;
    assign rdata_valid = r_rdata_valid;

    // LED driver outputs, derived directly from state so a store shows up
    // right after its edge; reset blanks the driver immediately.
    always_comb begin
        led_ctrl = 1'b0;
        led_word = 32'h0000_0000;
        if (rst) begin
            led_ctrl = 1'b0;
            led_word = 32'h0000_0000;
        end else begin
            case (r_mode)
                MODE_BLINK: begin
                    led_ctrl = r_phase;
                    led_word = {16'h0000, r_led};
                end
                MODE_ROTATE: begin
                    led_ctrl = 1'b1;
                    led_word = {16'h0000, r_disp};
                end
                default: begin
                    led_ctrl = 1'b1;
                    led_word = {16'h0000, r_led};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_led_reg.sv
module tb_mmio_led_reg;

    localparam logic [31:0] LED_A  = 32'hFFFF_FC60;
    localparam logic [31:0] MODE_A = 32'hFFFF_FC64;
    localparam logic [31:0] PER_A  = 32'hFFFF_FC68;
    localparam logic [23:0] P_RST  = 24'd12_500_000;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        led_ctrl;
    logic [31:0] led_word;

    int total;
    int bad;

    mmio_led_reg #(.LED_ADDR(LED_A), .PERIOD_RST(P_RST)) dut (
        .clk(clk), .rst(rst), .addr(addr), .mem_write(mem_write),
        .mem_read(mem_read), .wdata(wdata), .rdata(rdata),
        .rdata_valid(rdata_valid), .led_ctrl(led_ctrl), .led_word(led_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] e_rdata;
        logic        e_valid;
        logic        e_ctrl;
        logic [31:0] e_word;
    } vec_t;

    vec_t tbl[17];

    // Reference model state (behavioural, from the register rules).
    logic [15:0] m_led;
    logic [1:0]  m_mode;
    logic [23:0] m_period;
    longint      m_run;
    logic        m_phase;
    logic [15:0] m_disp;
    logic [31:0] m_rdata;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock, then idle the strobes 1 time unit later.
    task automatic cyc(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        mem_write = wr;
        mem_read  = rd;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
    endtask

    task automatic model_reset();
        m_led = 16'h0; m_mode = 2'd0; m_period = P_RST; m_run = 0;
        m_phase = 1'b1; m_disp = 16'h0; m_rdata = 32'h0; m_valid = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit hl, hm, hp;
        if (rst) begin
            model_reset();
        end else begin
            hl = (addr[31:2] == LED_A[31:2]);
            hm = (addr[31:2] == MODE_A[31:2]);
            hp = (addr[31:2] == PER_A[31:2]);
            if (mem_read && hl)      begin m_rdata = {16'h0, m_led};     m_valid = 1'b1; end
            else if (mem_read && hm) begin m_rdata = {30'h0, m_mode};    m_valid = 1'b1; end
            else if (mem_read && hp) begin m_rdata = {8'h0, m_period};   m_valid = 1'b1; end
            else                     begin m_rdata = 32'h0;              m_valid = 1'b0; end
            if (mem_write && hl) begin
                m_led = wdata[15:0]; m_disp = wdata[15:0]; m_run = 0; m_phase = 1'b1;
            end else if (mem_write && hm) begin
                m_mode = wdata[1:0]; m_disp = m_led; m_run = 0; m_phase = 1'b1;
            end else if (mem_write && hp) begin
                m_period = wdata[23:0]; m_run = 0;
            end else if (m_mode == 2'd1 || m_mode == 2'd2) begin
                m_run = m_run + 1;
                if (m_run % (longint'(m_period) + 1) == 0) begin
                    if (m_mode == 2'd1) m_phase = ~m_phase;
                    else m_disp = ((m_disp << 1) | (m_disp >> 15)) & 16'hFFFF;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] exp_word;
        logic        exp_ctrl;
        int          sel;
        total = 0;
        bad   = 0;
        rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0; addr = 32'h0; wdata = 32'h0;

        tbl[0]  = '{1'b0, 1'b1, LED_A,          32'h0,          32'h0,          1'b1, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, MODE_A,         32'h0,          32'h0,          1'b1, 1'b1, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, PER_A,          32'h0,          32'd12_500_000, 1'b1, 1'b1, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, LED_A,          32'h1234_A5A5,  32'h0,          1'b0, 1'b1, 32'h0000_A5A5};
        tbl[4]  = '{1'b1, 1'b0, 32'hFFFF_FC70,  32'hDEAD_BEEF,  32'h0,          1'b0, 1'b1, 32'h0000_A5A5};
        tbl[5]  = '{1'b0, 1'b1, 32'hFFFF_FC70,  32'h0,          32'h0,          1'b0, 1'b1, 32'h0000_A5A5};
        tbl[6]  = '{1'b0, 1'b1, LED_A,          32'h0,          32'h0000_A5A5,  1'b1, 1'b1, 32'h0000_A5A5};
        tbl[7]  = '{1'b1, 1'b0, LED_A,          32'h0000_FFFF,  32'h0,          1'b0, 1'b1, 32'h0000_FFFF};
        tbl[8]  = '{1'b1, 1'b1, LED_A,          32'h0000_0F0F,  32'h0000_FFFF,  1'b1, 1'b1, 32'h0000_0F0F};
        tbl[9]  = '{1'b0, 1'b1, 32'hFFFF_FC63,  32'h0,          32'h0000_0F0F,  1'b1, 1'b1, 32'h0000_0F0F};
        tbl[10] = '{1'b1, 1'b1, PER_A,          32'hAB00_0005,  32'd12_500_000, 1'b1, 1'b1, 32'h0000_0F0F};
        tbl[11] = '{1'b0, 1'b1, PER_A,          32'h0,          32'h0000_0005,  1'b1, 1'b1, 32'h0000_0F0F};
        tbl[12] = '{1'b1, 1'b0, MODE_A,         32'hFFFF_FFFF,  32'h0,          1'b0, 1'b1, 32'h0000_0F0F};
        tbl[13] = '{1'b0, 1'b1, MODE_A,         32'h0,          32'h0000_0003,  1'b1, 1'b1, 32'h0000_0F0F};
        tbl[14] = '{1'b0, 1'b1, 32'hFFFF_FC5C,  32'h0,          32'h0,          1'b0, 1'b1, 32'h0000_0F0F};
        tbl[15] = '{1'b0, 1'b1, 32'hFFFF_FC6C,  32'h0,          32'h0,          1'b0, 1'b1, 32'h0000_0F0F};
        tbl[16] = '{1'b1, 1'b0, MODE_A,         32'h0,          32'h0,          1'b0, 1'b1, 32'h0000_0F0F};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst ctrl", {31'h0, led_ctrl}, 32'h0);
        chk("rst word", led_word, 32'h0);
        chk("rst rdata", rdata, 32'h0);
        chk("rst valid", {31'h0, rdata_valid}, 32'h0);
        rst = 1'b0;
        #1;
        chk("post-rst ctrl", {31'h0, led_ctrl}, 32'h1);
        chk("post-rst word", led_word, 32'h0);

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d rdata", i), rdata, tbl[i].e_rdata);
            chk($sformatf("vec%0d valid", i), {31'h0, rdata_valid}, {31'h0, tbl[i].e_valid});
            chk($sformatf("vec%0d ctrl", i), {31'h0, led_ctrl}, {31'h0, tbl[i].e_ctrl});
            chk($sformatf("vec%0d word", i), led_word, tbl[i].e_word);
        end

        // Blink: period 3 gives 4 cycles on, 4 off, starting on
        cyc(1'b1, 1'b0, PER_A, 32'd3);
        cyc(1'b1, 1'b0, MODE_A, 32'd1);
        cyc(1'b1, 1'b0, LED_A, 32'h0000_00FF);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("blink ctrl k%0d", k), {31'h0, led_ctrl}, {31'h0, (((k / 4) % 2) == 0)});
            chk($sformatf("blink word k%0d", k), led_word, 32'h0000_00FF);
        end

        // Rotate every cycle with wrap of bit 15
        cyc(1'b1, 1'b0, PER_A, 32'd0);
        cyc(1'b1, 1'b0, MODE_A, 32'd2);
        cyc(1'b1, 1'b0, LED_A, 32'h0000_8001);
        chk("rot k0", led_word, 32'h0000_8001);
        @(posedge clk); #1;
        chk("rot k1", led_word, 32'h0000_0003);
        @(posedge clk); #1;
        chk("rot k2", led_word, 32'h0000_0006);
        @(posedge clk); #1;
        chk("rot k3", led_word, 32'h0000_000C);
        chk("rot ctrl", {31'h0, led_ctrl}, 32'h1);

        // Reset in the dark half of a blink, with a colliding store/load
        cyc(1'b1, 1'b0, PER_A, 32'd3);
        cyc(1'b1, 1'b0, MODE_A, 32'd1);
        cyc(1'b1, 1'b0, LED_A, 32'h0000_00FF);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
        end
        #1;
        chk("pre-rst dark", {31'h0, led_ctrl}, 32'h0);
        rst = 1'b1;
        mem_write = 1'b1; mem_read = 1'b1; addr = LED_A; wdata = 32'h0000_1234;
        #1;
        chk("rst comb ctrl", {31'h0, led_ctrl}, 32'h0);
        chk("rst comb word", led_word, 32'h0);
        @(posedge clk); #1;
        mem_write = 1'b0; mem_read = 1'b0;
        chk("rst edge ctrl", {31'h0, led_ctrl}, 32'h0);
        chk("rst edge word", led_word, 32'h0);
        chk("rst edge valid", {31'h0, rdata_valid}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rel ctrl", {31'h0, led_ctrl}, 32'h1);
        chk("rel word", led_word, 32'h0);
        cyc(1'b0, 1'b1, PER_A, 32'h0);
        chk("rel period", rdata, 32'd12_500_000);
        cyc(1'b0, 1'b1, MODE_A, 32'h0);
        chk("rel mode", rdata, 32'h0);
        cyc(1'b0, 1'b1, LED_A, 32'h0);
        chk("rel led", rdata, 32'h0);

        // Randomized traffic against the reference model
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 249) == 0);
            sel       = $urandom_range(0, 4);
            case (sel)
                0: addr = LED_A;
                1: addr = MODE_A;
                2: addr = PER_A;
                3: addr = 32'hFFFF_FC6C + 32'($urandom_range(0, 3)) * 32'd4;
                default: addr = $urandom;
            endcase
            addr[1:0] = 2'($urandom_range(0, 3));
            mem_write = ($urandom_range(0, 7) == 0);
            mem_read  = ($urandom_range(0, 2) == 0);
            wdata     = $urandom;
            if (sel == 2) wdata[23:0] = 24'($urandom_range(0, 6));
            model_step();
            @(posedge clk);
            #1;
            if (rst) begin
                exp_ctrl = 1'b0;
                exp_word = 32'h0;
            end else begin
                exp_ctrl = (m_mode == 2'd1) ? m_phase : 1'b1;
                exp_word = (m_mode == 2'd2) ? {16'h0, m_disp} : {16'h0, m_led};
            end
            chk($sformatf("rnd%0d rdata", n), rdata, m_rdata);
            chk($sformatf("rnd%0d valid", n), {31'h0, rdata_valid}, {31'h0, m_valid});
            chk($sformatf("rnd%0d ctrl", n), {31'h0, led_ctrl}, {31'h0, exp_ctrl});
            chk($sformatf("rnd%0d word", n), led_word, exp_word);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
